boot_load_ctrl: RTL

- Boot sequencer and memory-port owner between the UART receiver, the CPU load/store port and the data RAM (data_mem.ram) in cpu_uart_top.
- After reset it holds the CPU in reset and assembles UART bytes into 32-bit little-endian words, writing CELL_NUMBERS words into RAM.
- It then releases the CPU and hands the RAM port to the CPU as a pure mux.

---
 rtl/boot_pkg.sv | 16 +
 rtl/boot_word_asm.sv | 63 ++++++
 rtl/boot_load_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/boot_pkg.sv
// boot_pkg: shared definitions for the boot loader.
//   - boot_state_t : boot sequencer states. S_CHECK and S_ERR only exist when
//                    BOOT_CHECKSUM_EN is defined.
//   - BYTES_PER_WORD / BYTE_CNT_W : UART bytes per RAM word and counter width.
package boot_pkg;

   localparam int BYTES_PER_WORD = 4;
   localparam int BYTE_CNT_W     = 2;

`ifdef BOOT_CHECKSUM_EN
   typedef enum logic [2:0] {S_RECV, S_WRITE, S_CHECK, S_RUN, S_ERR} boot_state_t;
`else
   typedef enum logic [1:0] {S_RECV, S_WRITE, S_RUN} boot_state_t;
`endif

endpackage

// File: rtl/boot_word_asm.sv
// boot_word_asm: packs UART bytes into 32-bit little-endian words.
//   clk, rst    : clock, async active-high reset
//   byte_valid  : byte accepted this cycle
//   byte_data   : accepted byte
//   abort       : clear any partial word (held by the owner outside load)
//   word_valid  : combinational pulse, the 4th byte is being accepted
//   word        : assembled word, includes the byte being accepted
// A partial word is discarded after TIMEOUT idle cycles.
module boot_word_asm
   import boot_pkg::*;
#(
   parameter int TIMEOUT = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   input  logic        abort,
   output logic        word_valid,
   output logic [31:0] word
);

   localparam int IDLE_W = $clog2(TIMEOUT + 1);
   localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(BYTES_PER_WORD - 1);

   logic [BYTE_CNT_W-1:0] byte_cnt;
   logic [31:0]           shift_q;
   logic [IDLE_W-1:0]     idle_cnt;
   logic                  timeout;

   assign word_valid = byte_valid && (byte_cnt == LAST_BYTE);
   // Fires on the idle cycle that brings idle_cnt up to TIMEOUT.
   assign timeout    = !byte_valid && (byte_cnt != '0) &&
                       (idle_cnt == IDLE_W'(TIMEOUT - 1));

   // Word seen by the owner already carries the byte accepted this cycle,
   // so the write can be registered on the same edge.
   always_comb begin
      word = shift_q;
      word[{byte_cnt, 3'b000} +: 8] = byte_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_cnt <= '0;
         shift_q  <= '0;
         idle_cnt <= '0;
      end else if (abort) begin
         byte_cnt <= '0;
         idle_cnt <= '0;
      end else if (byte_valid) begin
         shift_q[{byte_cnt, 3'b000} +: 8] <= byte_data;
         byte_cnt <= (byte_cnt == LAST_BYTE) ? '0 : byte_cnt + BYTE_CNT_W'(1);
         idle_cnt <= '0;
      end else if (timeout) begin
         byte_cnt <= '0;
         idle_cnt <= '0;
      end else if (byte_cnt != '0) begin
         idle_cnt <= idle_cnt + IDLE_W'(1);
      end
   end

endmodule

// File: rtl/boot_load_ctrl.sv
// boot_load_ctrl: boot sequencer and data-RAM port owner.
// Holds the CPU in reset while CELL_NUMBERS words arrive over the UART, writes
// them to RAM from address 0, then releases the CPU and passes its load/store
// port straight through to the RAM.
//   rx_valid/rx_data/rx_ready : UART byte stream (accept on valid && ready)
//   cpu_mem_*                 : CPU port, ignored until the CPU owns the RAM
//   mem_*                     : RAM port (registered during load, mux in run)
//   cpu_rst                   : CPU reset, registered, high until load done
//   load_done                 : CPU owns the RAM
//   load_error                : checksum mismatch, 0 without BOOT_CHECKSUM_EN
// Optional: BOOT_CHECKSUM_EN adds a trailing checksum byte after the load.
module boot_load_ctrl
   import boot_pkg::*;
#(
   parameter int CELL_NUMBERS = 64,
   parameter int ADDR_W       = 8,
   parameter int TIMEOUT      = 1000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   input  logic              cpu_mem_we,
   input  logic [ADDR_W-1:0] cpu_mem_addr,
   input  logic [31:0]       cpu_mem_wdata,
   input  logic [3:0]        cpu_mem_be,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_be,
   output logic              cpu_rst,
   output logic              load_done,
   output logic              load_error
);

   localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(CELL_NUMBERS - 1);

   boot_state_t       state;
   logic [ADDR_W-1:0] word_cnt;
   logic              ld_we;
   logic [ADDR_W-1:0] ld_addr;
   logic [31:0]       ld_wdata;
   logic [3:0]        ld_be;
   logic              accept;
   logic              word_valid;
   logic [31:0]       asm_word;
   logic              run;

   assign accept = rx_valid && rx_ready && (state == S_RECV);
   assign run    = (state == S_RUN);

   boot_word_asm #(.TIMEOUT(TIMEOUT)) u_asm (
      .clk        (clk),
      .rst        (rst),
      .byte_valid (accept),
      .byte_data  (rx_data),
      .abort      (state != S_RECV),
      .word_valid (word_valid),
      .word       (asm_word)
   );

   // Zero-latency handover: once running, the CPU drives the RAM directly.
   assign mem_we    = run ? cpu_mem_we    : ld_we;
   assign mem_addr  = run ? cpu_mem_addr  : ld_addr;
   assign mem_wdata = run ? cpu_mem_wdata : ld_wdata;
   assign mem_be    = run ? cpu_mem_be    : ld_be;

`ifdef BOOT_CHECKSUM_EN
   logic [7:0] sum;
   logic [7:0] sum_next;

   assign sum_next = sum + rx_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         sum <= '0;
      else if (accept) sum <= sum_next;
   end
`else
   assign load_error = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_RECV;
         word_cnt  <= '0;
         rx_ready  <= 1'b1;
         cpu_rst   <= 1'b1;
         load_done <= 1'b0;
         ld_we     <= 1'b0;
         ld_addr   <= '0;
         ld_wdata  <= '0;
         ld_be     <= '0;
`ifdef BOOT_CHECKSUM_EN
         load_error <= 1'b0;
`endif
      end else begin
         ld_we <= 1'b0;
         case (state)
            S_RECV: begin
               if (word_valid) begin
                  state    <= S_WRITE;
                  rx_ready <= 1'b0;
                  ld_we    <= 1'b1;
                  ld_addr  <= word_cnt;
                  ld_wdata <= asm_word;
                  ld_be    <= 4'hF;
               end
            end
            S_WRITE: begin
               if (word_cnt == LAST_WORD) begin
`ifdef BOOT_CHECKSUM_EN
                  state    <= S_CHECK;
                  rx_ready <= 1'b1;
`else
                  state     <= S_RUN;
                  cpu_rst   <= 1'b0;
                  load_done <= 1'b1;
`endif
               end else begin
                  word_cnt <= word_cnt + ADDR_W'(1);
                  state    <= S_RECV;
                  rx_ready <= 1'b1;
               end
            end
`ifdef BOOT_CHECKSUM_EN
            // rx_ready is high here, so rx_valid means the byte is taken.
            S_CHECK: begin
               if (rx_valid) begin
                  rx_ready <= 1'b0;
                  if (sum_next == 8'h00) begin
                     state     <= S_RUN;
                     cpu_rst   <= 1'b0;
                     load_done <= 1'b1;
                  end else begin
                     state      <= S_ERR;
                     load_error <= 1'b1;
                  end
               end
            end
            S_ERR: ;
`endif
            S_RUN: ;
            default: state <= S_RECV;
         endcase
      end
   end

endmodule
